// File: rtl/rom_boot_loader.sv
// rom_boot_loader: copies LEN words from the synchronous-read instruction ROM into the
// scratch-pad memory at one word per clock. It also keeps a wrapping 32-bit checksum of
// the copied words.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   start                 one-cycle copy request, acted on only when idle
//   src_base/dst_base/len copy arguments, latched with start
//   rom_addr / rom_dout   ROM read port (data returns one clock after address)
//   spm_addr/spm_we/spm_wr_data  SPM write port
//   busy, done, checksum  status: in-flight flag, completion pulse, word sum
module rom_boot_loader #(
  parameter int unsigned ROM_ADDR_W = 11,
  parameter int unsigned SPM_ADDR_W = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ROM_ADDR_W-1:0] src_base,
  input  logic [SPM_ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]      len,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]     rom_dout,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_we,
  output logic [DATA_W-1:0]     spm_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     checksum
);

  localparam int unsigned ROM_SIZE = 2 ** ROM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;       // ROM addresses still to issue after the current one
  logic                  issue_q, issue_d;   // rom_addr holds a live read address
  logic                  rd_vld_q, rd_vld_d; // rom_dout carries a live word this cycle
  logic [SPM_ADDR_W-1:0] wr_ptr_q, wr_ptr_d; // SPM address for the next write
  logic [SPM_ADDR_W-1:0] spm_addr_q, spm_addr_d;
  logic                  spm_we_q, spm_we_d;
  logic [DATA_W-1:0]     spm_data_q, spm_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_W-1:0]     checksum_q, checksum_d;
  logic [LEN_W-1:0]      len_clamped;

  // Oversized requests are limited to the full ROM.
  assign len_clamped = (len > LEN_W'(ROM_SIZE)) ? LEN_W'(ROM_SIZE) : len;

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    cnt_d      = cnt_q;
    issue_d    = 1'b0;
    rd_vld_d   = issue_q;
    wr_ptr_d   = wr_ptr_q;
    spm_addr_d = spm_addr_q;
    spm_we_d   = 1'b0;
    spm_data_d = spm_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    checksum_d = checksum_q;

    // Write path runs off the ROM-latency pipeline, independent of state.
    if (rd_vld_q) begin
      spm_we_d   = 1'b1;
      spm_addr_d = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q + SPM_ADDR_W'(1);
      spm_data_d = rom_dout;
      checksum_d = checksum_q + rom_dout;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          checksum_d = '0;
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            rom_addr_d = src_base;
            wr_ptr_d   = dst_base;
            issue_d    = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = len_clamped - LEN_W'(1);
            state_d    = (len_clamped == LEN_W'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        rom_addr_d = rom_addr_q + ROM_ADDR_W'(1);
        cnt_d      = cnt_q - LEN_W'(1);
        issue_d    = 1'b1;
        if (cnt_q == LEN_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish once the last read has been written out.
        if (!issue_q && !rd_vld_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      cnt_q      <= '0;
      issue_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      wr_ptr_q   <= '0;
      spm_addr_q <= '0;
      spm_we_q   <= 1'b0;
      spm_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      cnt_q      <= cnt_d;
      issue_q    <= issue_d;
      rd_vld_q   <= rd_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      spm_addr_q <= spm_addr_d;
      spm_we_q   <= spm_we_d;
      spm_data_q <= spm_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      checksum_q <= checksum_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign spm_addr    = spm_addr_q;
  assign spm_we      = spm_we_q;
  assign spm_wr_data = spm_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign checksum    = checksum_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// tb_rom_boot_loader: directed bench for rom_boot_loader with a time-indexed reference
// model compared every cycle, plus literal expectations for each scenario.
module tb_rom_boot_loader;

  localparam int unsigned RAW = 11;
  localparam int unsigned SAW = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 12;

  logic           clk;
  logic           reset;
  logic           start;
  logic [RAW-1:0] src_base;
  logic [SAW-1:0] dst_base;
  logic [LW-1:0]  len;
  logic [RAW-1:0] rom_addr;
  logic [DW-1:0]  rom_dout;
  logic [SAW-1:0] spm_addr;
  logic           spm_we;
  logic [DW-1:0]  spm_wr_data;
  logic           busy;
  logic           done;
  logic [DW-1:0]  checksum;

  rom_boot_loader #(
    .ROM_ADDR_W(RAW), .SPM_ADDR_W(SAW), .DATA_W(DW), .LEN_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .src_base(src_base), .dst_base(dst_base),
    .len(len), .rom_addr(rom_addr), .rom_dout(rom_dout), .spm_addr(spm_addr),
    .spm_we(spm_we), .spm_wr_data(spm_wr_data), .busy(busy), .done(done),
    .checksum(checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read ROM.
  logic [DW-1:0] rom [0:(1<<RAW)-1];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: outputs as a function of edges elapsed since the accepted start.
  logic [RAW-1:0] m_rom_addr, m_src;
  logic [SAW-1:0] m_spm_addr, m_dst;
  logic [DW-1:0]  m_data, m_sum;
  logic           m_we, m_busy, m_done;
  bit             m_act;
  int             m_t, m_n;

  always @(posedge clk) begin
    if (reset) begin
      m_rom_addr = '0; m_spm_addr = '0; m_data = '0; m_sum = '0;
      m_we = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_act = 1'b0; m_t = 0; m_n = 0;
    end else begin
      m_done = 1'b0;
      m_we   = 1'b0;
      if (m_act) begin
        m_t++;
        if (m_t <= m_n - 1) m_rom_addr = m_src + RAW'(m_t);
        if (m_t >= 2 && m_t <= m_n + 1) begin
          m_we       = 1'b1;
          m_spm_addr = m_dst + SAW'(m_t - 2);
          m_data     = rom[m_src + RAW'(m_t - 2)];
          m_sum      = m_sum + m_data;
        end
        if (m_t == m_n + 2) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_act  = 1'b0;
        end
      end else if (start) begin
        m_n   = (len > LW'(2048)) ? 2048 : int'(len);
        m_src = src_base;
        m_dst = dst_base;
        m_sum = '0;
        if (m_n == 0) begin
          m_done = 1'b1;
        end else begin
          m_act      = 1'b1;
          m_t        = 0;
          m_busy     = 1'b1;
          m_rom_addr = src_base;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    chk("spm_we", 32'(spm_we), 32'(m_we));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("checksum", checksum, m_sum);
    if (m_we) begin
      chk("spm_addr", 32'(spm_addr), 32'(m_spm_addr));
      chk("spm_wr_data", spm_wr_data, m_data);
    end
  end

  logic [SAW-1:0] wa_q[$];
  logic [DW-1:0]  wd_q[$];
  logic [RAW-1:0] ra_q[$];
  int             done_cnt;
  bit             busy_seen;

  // Issue one copy from a negedge and observe until a few cycles past done.
  task automatic run(input logic [RAW-1:0] s, input logic [SAW-1:0] d, input logic [LW-1:0] l,
                     input int inj_rel, input int limit, output int first_we, output int done_rel);
    first_we = -1;
    done_rel = -1;
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    done_cnt  = 0;
    busy_seen = 1'b0;
    src_base = s; dst_base = d; len = l; start = 1'b1;
    for (int r = 0; r < limit; r++) begin
      @(negedge clk);
      start = 1'b0;
      if (r < 8) ra_q.push_back(rom_addr);
      if (busy) busy_seen = 1'b1;
      if (spm_we) begin
        if (first_we < 0) first_we = r;
        wa_q.push_back(spm_addr);
        wd_q.push_back(spm_wr_data);
      end
      if (done) begin
        done_cnt++;
        if (done_rel < 0) done_rel = r;
      end
      if (r == inj_rel) begin
        src_base = 11'h000; dst_base = 12'h055; len = 12'd3; start = 1'b1;
      end
      if (done_rel >= 0 && r >= done_rel + 3) break;
    end
    chk("done_seen", 32'(done_rel >= 0), 32'd1);
  endtask

  int fw, dr, nw, dn;

  initial begin
    for (int i = 0; i < (1 << RAW); i++) rom[i] = 32'(i) * 32'h9E3779B1 + 32'h00001234;
    rom[16] = 32'h11111111; rom[17] = 32'h22222222;
    rom[18] = 32'h33333333; rom[19] = 32'h44444444;

    // Reset held with start asserted.
    reset = 1'b1; start = 1'b1; src_base = 11'h010; dst_base = 12'h200; len = 12'd4;
    repeat (3) @(negedge clk);
    chk("rst_spm_we", 32'(spm_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    // Basic copy.
    run(11'h010, 12'h200, 12'd4, -1, 40, fw, dr);
    chk("basic_first_we", 32'(fw), 32'd2);
    chk("basic_done_rel", 32'(dr), 32'd6);
    chk("basic_nwrites", 32'(wa_q.size()), 32'd4);
    chk("basic_addr0", 32'(wa_q[0]), 32'h200);
    chk("basic_addr3", 32'(wa_q[3]), 32'h203);
    chk("basic_data1", wd_q[1], 32'h22222222);
    chk("basic_data3", wd_q[3], 32'h44444444);
    chk("basic_checksum", checksum, 32'hAAAAAAAA);

    // Zero length.
    run(11'h010, 12'h200, 12'd0, -1, 20, fw, dr);
    chk("zero_done_rel", 32'(dr), 32'd0);
    chk("zero_busy_seen", 32'(busy_seen), 32'd0);
    chk("zero_nwrites", 32'(wa_q.size()), 32'd0);
    chk("zero_checksum", checksum, 32'd0);

    // Address wrap on both sides.
    run(11'h7FE, 12'hFFF, 12'd4, -1, 40, fw, dr);
    chk("wrap_ra0", 32'(ra_q[0]), 32'h7FE);
    chk("wrap_ra1", 32'(ra_q[1]), 32'h7FF);
    chk("wrap_ra2", 32'(ra_q[2]), 32'h000);
    chk("wrap_ra3", 32'(ra_q[3]), 32'h001);
    chk("wrap_wa0", 32'(wa_q[0]), 32'hFFF);
    chk("wrap_wa1", 32'(wa_q[1]), 32'h000);
    chk("wrap_wa3", 32'(wa_q[3]), 32'h002);
    chk("wrap_data2", wd_q[2], rom[0]);

    // Start mid-copy is ignored.
    run(11'h100, 12'h400, 12'd5, 2, 40, fw, dr);
    chk("ign_done_cnt", 32'(done_cnt), 32'd1);
    chk("ign_done_rel", 32'(dr), 32'd7);
    chk("ign_nwrites", 32'(wa_q.size()), 32'd5);
    chk("ign_addr4", 32'(wa_q[4]), 32'h404);
    chk("ign_data4", wd_q[4], rom[11'h104]);

    // Abort after the second write.
    nw = 0; dn = 0;
    src_base = 11'h020; dst_base = 12'h300; len = 12'd8; start = 1'b1;
    for (int r = 0; r < 30; r++) begin
      @(negedge clk);
      start = 1'b0;
      if (spm_we) nw++;
      if (done) dn++;
      if (nw == 2) break;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_spm_we", 32'(spm_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (12) begin
      @(negedge clk);
      if (spm_we) nw++;
      if (done) dn++;
    end
    chk("abort_nwrites", 32'(nw), 32'd2);
    chk("abort_no_done", 32'(dn), 32'd0);
    run(11'h040, 12'h010, 12'd1, -1, 20, fw, dr);
    chk("post_abort_nwrites", 32'(wa_q.size()), 32'd1);
    chk("post_abort_done_rel", 32'(dr), 32'd3);
    chk("post_abort_data", wd_q[0], rom[11'h040]);

    // Oversized length clamps to the full ROM.
    run(11'h000, 12'h000, 12'hFFF, -1, 2100, fw, dr);
    chk("clamp_nwrites", 32'(wa_q.size()), 32'd2048);
    chk("clamp_done_rel", 32'(dr), 32'd2050);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
